// File: rtl/plru_array_pkg.sv
// Shared types and tree helpers for the per-set pseudo-LRU replacement store.
// Helpers work on the widest supported tree; callers zero-extend and truncate.
package plru_array_pkg;

   localparam int unsigned DEF_WAYS   = 4;
   localparam int unsigned DEF_SETS   = 16;
   localparam int unsigned MAX_WAYS   = 16;
   localparam int unsigned MAX_WAY_W  = $clog2(MAX_WAYS);
   localparam int unsigned MAX_TREE_W = MAX_WAYS - 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } plru_state_e;

   // Walk from the root along the way's bits (MSB first), marking each node with that bit.
   function automatic logic [MAX_TREE_W-1:0] plru_touch(input logic [MAX_TREE_W-1:0] tree,
                                                        input logic [MAX_WAY_W-1:0]  way,
                                                        input int                    levels);
      logic [MAX_TREE_W-1:0] t;
      int                    node;
      t    = tree;
      node = 0;
      for (int l = int'(MAX_WAY_W) - 1; l >= 0; l--) begin
         if (l < levels) begin
            t[node] = way[l];
            node    = 2 * node + 1 + int'(way[l]);
         end
      end
      return t;
   endfunction

   // Descend toward the least recently used half at every node.
   function automatic logic [MAX_WAY_W-1:0] plru_victim(input logic [MAX_TREE_W-1:0] tree,
                                                        input int                    levels);
      logic [MAX_WAY_W-1:0] w;
      logic                 b;
      int                   node;
      w    = '0;
      node = 0;
      for (int l = 0; l < int'(MAX_WAY_W); l++) begin
         if (l < levels) begin
            b    = ~tree[node];
            w    = {w[MAX_WAY_W-2:0], b};
            node = 2 * node + 1 + int'(b);
         end
      end
      return w;
   endfunction

   function automatic logic [MAX_WAY_W-1:0] first_zero(input logic [MAX_WAYS-1:0] mask,
                                                       input int                  ways);
      logic [MAX_WAY_W-1:0] idx;
      idx = '0;
      for (int i = int'(MAX_WAYS) - 1; i >= 0; i--) begin
         if (i < ways && !mask[i]) idx = MAX_WAY_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational PLRU tree update (touch) and victim selection for one tree.
module plru_tree_logic
   import plru_array_pkg::*;
#(
   parameter int unsigned WAYS = DEF_WAYS
) (
   input  logic [WAYS-2:0]         upd_tree,
   input  logic [$clog2(WAYS)-1:0] touch_way,
   output logic [WAYS-2:0]         touched_c,
   input  logic [WAYS-2:0]         sel_tree,
   input  logic [WAYS-1:0]         way_valid,
   output logic [$clog2(WAYS)-1:0] victim_c
);

   localparam int unsigned TREE_W = WAYS - 1;
   localparam int unsigned WAY_W  = $clog2(WAYS);

   logic [MAX_WAY_W-1:0] tree_vic;
   logic [MAX_WAY_W-1:0] free_way;

   // Invalid ways take priority over the tree's choice.
   always_comb begin
      touched_c = TREE_W'(plru_touch(MAX_TREE_W'(upd_tree), MAX_WAY_W'(touch_way), int'(WAY_W)));
      tree_vic  = plru_victim(MAX_TREE_W'(sel_tree), int'(WAY_W));
      free_way  = first_zero(MAX_WAYS'(way_valid), int'(WAYS));
      victim_c  = (&way_valid) ? WAY_W'(tree_vic) : WAY_W'(free_way);
   end

endmodule

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU store: clear walk, touch read-modify-write and registered lookup.
module plru_array
   import plru_array_pkg::*;
#(
   parameter int unsigned WAYS = DEF_WAYS,
   parameter int unsigned SETS = DEF_SETS
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ready,
   input  logic                    clear,
   input  logic                    lookup_valid,
   input  logic [$clog2(SETS)-1:0] lookup_set,
   input  logic [WAYS-1:0]         way_valid,
   output logic                    victim_valid,
   output logic [$clog2(WAYS)-1:0] victim_way,
   input  logic                    touch_valid,
   input  logic [$clog2(SETS)-1:0] touch_set,
   input  logic [$clog2(WAYS)-1:0] touch_way
);

   localparam int unsigned WAY_W  = $clog2(WAYS);
   localparam int unsigned SET_W  = $clog2(SETS);
   localparam int unsigned TREE_W = WAYS - 1;

   logic [TREE_W-1:0] mem [SETS];

   plru_state_e       state_q, state_d;
   logic [SET_W-1:0]  cnt_q, cnt_d;
   logic              ready_q;
   logic              vv_q;
   logic [TREE_W-1:0] tree_q;

   logic              touch_ok_c;
   logic              lookup_ok_c;
   logic              wr_en_c;
   logic [SET_W-1:0]  wr_set_c;
   logic [TREE_W-1:0] wr_data_c;
   logic [TREE_W-1:0] touched_c;
   logic [TREE_W-1:0] fwd_tree_c;
   logic [WAY_W-1:0]  victim_c;

   plru_tree_logic #(.WAYS(WAYS)) u_tree (
      .upd_tree  (mem[touch_set]),
      .touch_way (touch_way),
      .touched_c (touched_c),
      .sel_tree  (tree_q),
      .way_valid (way_valid),
      .victim_c  (victim_c)
   );

   // Clear walk owns the write port; otherwise a touch may use it unless clear starts.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      touch_ok_c  = 1'b0;
      lookup_ok_c = 1'b0;
      wr_en_c     = 1'b0;
      wr_set_c    = touch_set;
      wr_data_c   = touched_c;
      case (state_q)
         ST_CLEAR: begin
            wr_en_c   = 1'b1;
            wr_set_c  = cnt_q;
            wr_data_c = '0;
            cnt_d     = cnt_q + SET_W'(1);
            if (cnt_q == SET_W'(SETS - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            lookup_ok_c = lookup_valid;
            if (clear) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else begin
               touch_ok_c = touch_valid;
               wr_en_c    = touch_valid;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Same-cycle touch to the looked-up set is forwarded into the captured tree.
   assign fwd_tree_c = (touch_ok_c && (touch_set == lookup_set)) ? touched_c : mem[lookup_set];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         vv_q    <= 1'b0;
         tree_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == ST_IDLE);
         vv_q    <= lookup_ok_c;
         if (lookup_ok_c) tree_q <= fwd_tree_c;
      end
   end

   // Storage has no reset so it can map onto a register file or SRAM.
   always_ff @(posedge clk) begin
      if (wr_en_c) mem[wr_set_c] <= wr_data_c;
   end

   assign ready        = ready_q;
   assign victim_valid = vv_q;
   assign victim_way   = vv_q ? victim_c : '0;

endmodule
